// File: rtl/cacheline_adaptor.sv
// Cache-line to memory-burst adaptor: one LINE_W read or writeback becomes a
// BEATS-long burst of BURST_W beats (beat 0 = lowest-addressed word), and a
// single-cycle resp_o strobe is returned to the cache controller.
module cacheline_adaptor #(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  // Cache side
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  // Memory side
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int unsigned Beats = LINE_W / BURST_W;
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned OffW  = $clog2(LINE_W / 8);
  localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

  typedef enum logic [1:0] {StIdle, StRdBurst, StWrBurst, StDone} state_e;

  state_e            state;
  logic [CntW-1:0]   cnt;
  logic [LINE_W-1:0] wbuf;

  // Control FSM with registered request/response outputs and beat datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      cnt       <= '0;
      wbuf      <= '0;
      line_o    <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      resp_o <= 1'b0;
      unique case (state)
        StIdle: begin
          // Write wins when both requests are raised together.
          if (write_i) begin
            address_o <= {address_i[31:OffW], {OffW{1'b0}}};
            wbuf      <= line_i;
            cnt       <= '0;
            write_o   <= 1'b1;
            state     <= StWrBurst;
          end else if (read_i) begin
            address_o <= {address_i[31:OffW], {OffW{1'b0}}};
            cnt       <= '0;
            read_o    <= 1'b1;
            state     <= StRdBurst;
          end
        end
        StRdBurst: begin
          if (resp_i) begin
            line_o[BURST_W*cnt +: BURST_W] <= burst_i;
            cnt <= cnt + 1'b1;
            if (cnt == LastCnt) begin
              read_o <= 1'b0;
              resp_o <= 1'b1;
              state  <= StDone;
            end
          end
        end
        StWrBurst: begin
          if (resp_i) begin
            cnt <= cnt + 1'b1;
            if (cnt == LastCnt) begin
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              state   <= StDone;
            end
          end
        end
        StDone: begin
          // Requests are deliberately not sampled here; the cache drops them.
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Present the current write beat; held until memory acknowledges it.
  always_comb begin
    burst_o = '0;
    if (state == StWrBurst) begin
      burst_o = wbuf[BURST_W*cnt +: BURST_W];
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed scenarios followed by
// randomized read/write transactions checked against a beat-level model.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int n_cmp = 0;
  int n_err = 0;
  logic [255:0] last_line;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // Called at a negedge with the adaptor idle; returns at a negedge, idle again
  // (or already re-requesting when hold=1).
  task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                         input logic [15:0] pat, input bit use_pat, input bit hold);
    int  k   = 0;
    int  cyc = 0;
    bit  r;
    read_i    = 1'b1;
    write_i   = 1'b0;
    address_i = addr;
    resp_i    = 1'b0;
    @(negedge clk);
    address_i = $urandom;  // latched already, must not matter
    chk("rd address_o", 256'(address_o), 256'({addr[31:5], 5'b0}));
    while (k < 4) begin
      chk("rd read_o", 256'(read_o), 256'(1));
      chk("rd resp_o low", 256'(resp_o), 256'(0));
      r = use_pat ? pat[cyc] : (($urandom_range(0, 2) != 0) || cyc > 30);
      resp_i  = r;
      burst_i = r ? line[64*k +: 64] : 64'({$urandom, $urandom});
      @(negedge clk);
      if (r) k++;
      cyc++;
    end
    resp_i = 1'b0;
    chk("rd resp_o pulse", 256'(resp_o), 256'(1));
    chk("rd read_o drop", 256'(read_o), 256'(0));
    chk("rd line_o", line_o, line);
    last_line = line;
    if (!hold) read_i = 1'b0;
    @(negedge clk);
    chk("rd resp_o end", 256'(resp_o), 256'(0));
    chk("rd read_o end", 256'(read_o), 256'(0));
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                          input logic [15:0] pat, input bit use_pat, input bit also_read);
    int  k   = 0;
    int  cyc = 0;
    bit  r;
    write_i   = 1'b1;
    read_i    = also_read;
    address_i = addr;
    line_i    = line;
    resp_i    = 1'b0;
    @(negedge clk);
    line_i    = rand_line();  // latched already, must not matter
    address_i = $urandom;
    chk("wr address_o", 256'(address_o), 256'({addr[31:5], 5'b0}));
    while (k < 4) begin
      chk("wr write_o", 256'(write_o), 256'(1));
      chk("wr read_o", 256'(read_o), 256'(0));
      chk("wr burst_o", 256'(burst_o), 256'(line[64*k +: 64]));
      chk("wr resp_o low", 256'(resp_o), 256'(0));
      r = use_pat ? pat[cyc] : (($urandom_range(0, 2) != 0) || cyc > 30);
      resp_i = r;
      @(negedge clk);
      if (r) k++;
      cyc++;
    end
    resp_i = 1'b0;
    chk("wr resp_o pulse", 256'(resp_o), 256'(1));
    chk("wr write_o drop", 256'(write_o), 256'(0));
    chk("wr line_o kept", line_o, last_line);
    write_i = 1'b0;
    read_i  = 1'b0;
    @(negedge clk);
    chk("wr resp_o end", 256'(resp_o), 256'(0));
  endtask

  initial begin
    logic [255:0] l;
    rst       = 1'b1;
    line_i    = '0;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    burst_i   = '0;
    resp_i    = 1'b0;
    last_line = '0;

    // Reset state
    @(negedge clk);
    chk("rst line_o", line_o, '0);
    chk("rst resp_o", 256'(resp_o), 256'(0));
    chk("rst read_o", 256'(read_o), 256'(0));
    chk("rst write_o", 256'(write_o), 256'(0));
    chk("rst address_o", 256'(address_o), 256'(0));
    chk("rst burst_o", 256'(burst_o), 256'(0));
    rst = 1'b0;
    @(negedge clk);

    // Spurious resp_i in idle
    resp_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle resp_o", 256'(resp_o), 256'(0));
      chk("idle read_o", 256'(read_o), 256'(0));
      chk("idle write_o", 256'(write_o), 256'(0));
    end
    resp_i = 1'b0;

    // Read, back-to-back beats
    do_read(32'h0000_1234, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}},
            16'h000f, 1'b1, 1'b0);

    // Write with gaps: resp pattern 1,0,0,1,1,0,1
    do_write(32'h8000_00ff, rand_line(), 16'h0059, 1'b1, 1'b0);

    // Simultaneous read and write requests: write wins
    do_write(32'h0001_0040, rand_line(), 16'h000f, 1'b1, 1'b1);

    // Reset after two read beats
    l = rand_line();
    read_i    = 1'b1;
    address_i = 32'h0000_2000;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      resp_i  = 1'b1;
      burst_i = l[64*i +: 64];
      @(negedge clk);
    end
    resp_i = 1'b0;
    rst    = 1'b1;
    #1;
    chk("arst line_o", line_o, '0);
    chk("arst read_o", 256'(read_o), 256'(0));
    chk("arst address_o", 256'(address_o), 256'(0));
    chk("arst resp_o", 256'(resp_o), 256'(0));
    read_i    = 1'b0;
    last_line = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst read_o", 256'(read_o), 256'(0));
    chk("post-rst resp_o", 256'(resp_o), 256'(0));
    do_read(32'h0000_3010, rand_line(), 16'h000f, 1'b1, 1'b0);

    // Request held past resp_o starts a second transaction
    l = rand_line();
    do_read(32'h0000_4000, l, 16'h000f, 1'b1, 1'b1);
    do_read(32'h0000_4000, rand_line(), 16'h0000, 1'b0, 1'b0);

    // Randomized transactions
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 0)
        do_read($urandom, rand_line(), 16'h0000, 1'b0, 1'b0);
      else
        do_write($urandom, rand_line(), 16'h0000, 1'b0, ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
